// File: rtl/wb_arbiter_pkg.sv
// Shared constants and helpers for the writeback arbiter.
// The index constants name the producing units; WIDTH_DEF matches the
// shared 32-bit datapath width. RNUM_W is the register-number width.
package wb_arbiter_pkg;

  localparam int NSRC_DEF  = 3;
  localparam int SRC_ALU   = 0;
  localparam int SRC_FPU   = 1;
  localparam int SRC_LSU   = 2;
  localparam int RNUM_W    = 5;
  localparam int WIDTH_DEF = 32;

  // True for a write that targets general-purpose register r0.
  function automatic logic is_zero_dst(input logic gf, input logic [RNUM_W-1:0] num);
    return (!gf && (num == '0));
  endfunction

endpackage

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter with a persistent priority pointer.
// The search starts at the pointer and wraps; after a grant to slot k
// that is accepted (advance high) the pointer moves to k+1 mod N.
// Reusable by other arbiters (e.g. the memory-port arbiter).
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic         any
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next_ptr;

  // Pick the first requester at or above the pointer, otherwise the first below it.
  always_comb begin
    grant      = '0;
    any        = 1'b0;
    w_next_ptr = r_ptr;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (i >= int'(r_ptr))) begin
        grant[i]   = 1'b1;
        any        = 1'b1;
        w_next_ptr = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        grant[i]   = 1'b1;
        any        = 1'b1;
        w_next_ptr = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // Pointer moves only when a grant is actually consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance && any) begin
      r_ptr <= w_next_ptr;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding slot per producing unit, round-robin
// selection of a full slot, and one registered register-file write per cycle.
// Handshake: a unit transfers on a rising edge where src_valid[i] & src_ready[i];
// src_ready[i] depends only on slot state (empty, or being granted this cycle),
// never on src_valid, so a granted slot can be refilled on the same edge.
// Optional macro WB_ZERO_GUARD_EN: results targeting general r0 are accepted
// and discarded without occupying a slot.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NSRC  = NSRC_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSRC-1:0]         src_valid,
  output logic [NSRC-1:0]         src_ready,
  input  logic [NSRC-1:0]         src_gfflag,
  input  logic [RNUM_W*NSRC-1:0]  src_num,
  input  logic [WIDTH*NSRC-1:0]   src_data,
  output logic                    r_gfflag,
  output logic [RNUM_W-1:0]       r_num,
  output logic [WIDTH-1:0]        r_data,
  output logic                    enable,
  output logic                    wb_idle
);

  logic [NSRC-1:0]   r_full;
  logic [NSRC-1:0]   r_slot_gf;
  logic [RNUM_W-1:0] r_slot_num  [NSRC];
  logic [WIDTH-1:0]  r_slot_data [NSRC];

  logic [NSRC-1:0]   w_grant;
  logic              w_any;
  logic [NSRC-1:0]   w_take;
  logic [NSRC-1:0]   w_drop;
  logic              w_win_gf;
  logic [RNUM_W-1:0] w_win_num;
  logic [WIDTH-1:0]  w_win_data;

  // Every grant is consumed immediately by the output register.
  rr_arbiter #(.N(NSRC)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (r_full),
    .advance (1'b1),
    .grant   (w_grant),
    .any     (w_any)
  );

  assign src_ready = ~r_full | w_grant;
  assign w_take    = src_valid & src_ready;
  assign wb_idle   = ~(|r_full) & ~enable;

  // Flag incoming results that must be swallowed instead of buffered.
  always_comb begin
    w_drop = '0;
`ifdef WB_ZERO_GUARD_EN
    for (int i = 0; i < NSRC; i++) begin
      w_drop[i] = is_zero_dst(src_gfflag[i], src_num[RNUM_W*i +: RNUM_W]);
    end
`endif
  end

  // Slot capture and release; a capture on the grant edge keeps the slot full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= '0;
      r_slot_gf <= '0;
      for (int i = 0; i < NSRC; i++) begin
        r_slot_num[i]  <= '0;
        r_slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (w_take[i]) begin
          r_full[i]      <= ~w_drop[i];
          r_slot_gf[i]   <= src_gfflag[i];
          r_slot_num[i]  <= src_num[RNUM_W*i +: RNUM_W];
          r_slot_data[i] <= src_data[WIDTH*i +: WIDTH];
        end else if (w_grant[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  // Select the granted slot's payload (grant is one-hot).
  always_comb begin
    w_win_gf   = 1'b0;
    w_win_num  = '0;
    w_win_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_grant[i]) begin
        w_win_gf   = r_slot_gf[i];
        w_win_num  = r_slot_num[i];
        w_win_data = r_slot_data[i];
      end
    end
  end

  // Output write register; payload holds when no write is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gfflag <= 1'b0;
      r_num    <= '0;
      r_data   <= '0;
      enable   <= 1'b0;
    end else if (w_any) begin
      r_gfflag <= w_win_gf;
      r_num    <= w_win_num;
      r_data   <= w_win_data;
      enable   <= 1'b1;
    end else begin
      enable   <= 1'b0;
    end
  end

endmodule
